// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result stream and the buffered memory-return
// stream onto the single register-file write port, with starvation protection.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module wb_arbiter #(
    parameter int unsigned WIDTH        = `WORD_WIDTH,
    parameter int unsigned COUNT        = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ZERO_REG     = 1,
    localparam int unsigned ADDR_WIDTH  = $clog2(COUNT),
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_data,
    output logic                  we_d,
    output logic [ADDR_WIDTH-1:0] addr_d,
    output logic [WIDTH-1:0]      d,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } wr_t;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

    arb_state_t      state_q, state_next;
    logic [SW-1:0]   starve_q, starve_next;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    wr_t             fifo_mem [FIFO_DEPTH];

    wr_t  head, sel_wr;
    logic fifo_empty, mem_hs;
    logic grant, pop, push, bypass;

    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (fifo_count == '0);
    assign mem_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign alu_ready  = (state_q == ARB_NORMAL);
    assign mem_hs     = mem_valid && mem_ready;

    // Grant selection, FIFO control and starvation tracking
    always_comb begin
        grant       = 1'b0;
        pop         = 1'b0;
        bypass      = 1'b0;
        sel_wr      = '0;
        state_next  = state_q;
        starve_next = starve_q;

        if (state_q == ARB_FORCE && !fifo_empty) begin
            grant  = 1'b1;
            pop    = 1'b1;
            sel_wr = head;
        end else if (alu_valid && alu_ready) begin
            grant  = 1'b1;
            sel_wr = '{addr: alu_addr, data: alu_data};
        end else if (!fifo_empty) begin
            grant  = 1'b1;
            pop    = 1'b1;
            sel_wr = head;
        end else if (mem_hs) begin
            grant  = 1'b1;
            bypass = 1'b1;
            sel_wr = '{addr: mem_addr, data: mem_data};
        end

        push = mem_hs && !bypass;

        if (fifo_empty || pop) begin
            starve_next = '0;
        end else begin
            starve_next = starve_q + SW'(1);
        end

        state_next = (starve_next == SW'(STARVE_LIMIT)) ? ARB_FORCE : ARB_NORMAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_next;
            starve_q <= starve_next;
        end
    end

    // FIFO pointers and occupancy; contents are simply abandoned on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_count <= '0;
        end else begin
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= '{addr: mem_addr, data: mem_data};
    end

    // Registered write port; register-0 writes consume the slot but never assert we_d
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_d   <= 1'b0;
            addr_d <= '0;
            d      <= '0;
        end else begin
            we_d <= grant && !((ZERO_REG != 0) && (sel_wr.addr == '0));
            if (grant) begin
                addr_d <= sel_wr.addr;
                d      <= sel_wr.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with default parameters.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        we_d;
    logic [4:0]  addr_d;
    logic [31:0] d;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .we_d(we_d), .addr_d(addr_d), .d(d), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 64'(we_d), 64'd0);
        chk("rst_addr", 64'(addr_d), 64'd0);
        chk("rst_d", 64'(d), 64'd0);
        chk("rst_cnt", 64'(fifo_count), 64'd0);
        chk("rst_mem_ready", 64'(mem_ready), 64'd1);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // ALU write, one-cycle latency, single-cycle pulse
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        chk("alu_ready_idle", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        chk("alu_we", 64'(we_d), 64'd1);
        chk("alu_addr", 64'(addr_d), 64'd5);
        chk("alu_d", 64'(d), 64'hDEADBEEF);
        tick();
        chk("alu_we_drop", 64'(we_d), 64'd0);
        chk("alu_addr_hold", 64'(addr_d), 64'd5);

        // Bypass with empty FIFO
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h11;
        tick();
        mem_valid = 1'b0;
        chk("byp_we", 64'(we_d), 64'd1);
        chk("byp_addr", 64'(addr_d), 64'd7);
        chk("byp_d", 64'(d), 64'h11);
        chk("byp_cnt", 64'(fifo_count), 64'd0);

        // Starvation: ALU held while two returns queue up
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
        tick();
        chk("stv_cnt1", 64'(fifo_count), 64'd1);
        mem_addr = 5'd4; mem_data = 32'h44;
        tick();
        mem_valid = 1'b0;
        chk("stv_cnt2", 64'(fifo_count), 64'd2);
        chk("stv_mem_ready", 64'(mem_ready), 64'd0);
        chk("stv_alu_addr", 64'(addr_d), 64'd9);
        for (int i = 0; i < 3; i++) begin
            chk("stv_alu_ready_hi", 64'(alu_ready), 64'd1);
            tick();
            chk("stv_alu_win", 64'(addr_d), 64'd9);
        end
        chk("stv_force", 64'(alu_ready), 64'd0);
        tick();
        chk("stv_pop_we", 64'(we_d), 64'd1);
        chk("stv_pop_addr", 64'(addr_d), 64'd3);
        chk("stv_pop_d", 64'(d), 64'h33);
        chk("stv_alu_ready_back", 64'(alu_ready), 64'd1);
        chk("stv_cnt_after", 64'(fifo_count), 64'd1);
        alu_valid = 1'b0;
        tick();
        chk("stv_pop2_addr", 64'(addr_d), 64'd4);
        chk("stv_pop2_d", 64'(d), 64'h44);
        chk("stv_cnt_empty", 64'(fifo_count), 64'd0);

        // Register 0 write is consumed but suppressed
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFF;
        chk("zr_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        chk("zr_we", 64'(we_d), 64'd0);

        // Push and pop together at occupancy 1
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h10;
        mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h12;
        tick();
        chk("pp_cnt_pre", 64'(fifo_count), 64'd1);
        alu_valid = 1'b0;
        mem_addr = 5'd13; mem_data = 32'h13;
        tick();
        mem_valid = 1'b0;
        chk("pp_cnt", 64'(fifo_count), 64'd1);
        chk("pp_addr", 64'(addr_d), 64'd12);
        chk("pp_d", 64'(d), 64'h12);
        tick();
        chk("pp_addr2", 64'(addr_d), 64'd13);
        chk("pp_d2", 64'(d), 64'h13);
        chk("pp_cnt_empty", 64'(fifo_count), 64'd0);

        // Asynchronous reset with a full FIFO
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_addr = 5'd20; mem_data = 32'h20;
        tick();
        mem_addr = 5'd21; mem_data = 32'h21;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("ar_cnt_full", 64'(fifo_count), 64'd2);
        chk("ar_we_pre", 64'(we_d), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", 64'(we_d), 64'd0);
        chk("ar_addr", 64'(addr_d), 64'd0);
        chk("ar_d", 64'(d), 64'd0);
        chk("ar_cnt", 64'(fifo_count), 64'd0);
        chk("ar_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_we", 64'(we_d), 64'd0);
        chk("ar_post_cnt", 64'(fifo_count), 64'd0);
        tick();
        chk("ar_post_we2", 64'(we_d), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
